// File: rtl/game_controller.sv
// Game-flow controller: IDLE -> PLAYING -> DYING -> (PLAYING | GAME_OVER), with score,
// high score and lives tracking. Every output is a register; nothing flows combinationally from input to output.
module game_controller #(
  parameter int LIVES        = 3,
  parameter int FREEZE_TICKS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_button,
  input  logic       game_tick,
  input  logic       collided,
  input  logic       pipe_passed,
  output logic [1:0] state,
  output logic       run_en,
  output logic       position_reset,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [1:0] lives
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    DYING     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
  localparam logic [7:0] FREEZE_LAST = 8'(FREEZE_TICKS - 1);

  state_t     st;
  logic       start_q;
  logic [7:0] freeze;
  logic       start_edge;

  // start_q resets high so a button held through reset yields no edge
  assign start_edge = start_button & ~start_q;
  assign state      = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st             <= IDLE;
      run_en         <= 1'b0;
      position_reset <= 1'b1;
      score          <= 8'd0;
      high_score     <= 8'd0;
      lives          <= LIVES_INIT;
      freeze         <= 8'd0;
      start_q        <= 1'b1;
    end else begin
      start_q <= start_button;
      case (st)
        IDLE: begin
          run_en         <= 1'b0;
          position_reset <= 1'b1;
          if (start_edge) begin
            st             <= PLAYING;
            run_en         <= 1'b1;
            position_reset <= 1'b0;
            score          <= 8'd0;
            lives          <= LIVES_INIT;
          end
        end
        PLAYING: begin
          run_en         <= 1'b1;
          position_reset <= 1'b0;
          if (collided) begin
            st     <= DYING;
            run_en <= 1'b0;
            lives  <= lives - 2'd1;
            freeze <= 8'd0;
          end else if (pipe_passed && score != 8'hff) begin
            score <= score + 8'd1;
          end
        end
        DYING: begin
          run_en         <= 1'b0;
          position_reset <= 1'b0;
          if (game_tick) begin
            if (freeze == FREEZE_LAST) begin
              // the resume cycle carries position_reset so pipes/bird restart cleanly
              position_reset <= 1'b1;
              if (lives == 2'd0) begin
                st <= GAME_OVER;
                if (score > high_score) high_score <= score;
              end else begin
                st     <= PLAYING;
                run_en <= 1'b1;
              end
            end else begin
              freeze <= freeze + 8'd1;
            end
          end
        end
        GAME_OVER: begin
          run_en         <= 1'b0;
          position_reset <= 1'b1;
          if (start_edge) st <= IDLE;
        end
        default: begin
          st             <= IDLE;
          run_en         <= 1'b0;
          position_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: directed stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_game_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_button = 1'b0;
  logic       game_tick = 1'b0;
  logic       collided = 1'b0;
  logic       pipe_passed = 1'b0;
  logic [1:0] state;
  logic       run_en;
  logic       position_reset;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [1:0] lives;

  game_controller #(.LIVES(3), .FREEZE_TICKS(4)) dut (
    .clk(clk), .reset(reset), .start_button(start_button), .game_tick(game_tick),
    .collided(collided), .pipe_passed(pipe_passed), .state(state), .run_en(run_en),
    .position_reset(position_reset), .score(score), .high_score(high_score), .lives(lives)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       re;
    logic       pr;
    logic [7:0] sc;
    logic [7:0] hs;
    logic [1:0] lv;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  logic [1:0] e_st;
  logic       e_re, e_pr;
  logic [7:0] e_sc, e_hs;
  logic [1:0] e_lv;

  // monitor: outputs settle after posedge, compare on the following negedge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (state === e.st && run_en === e.re && position_reset === e.pr &&
          score === e.sc && high_score === e.hs && lives === e.lv)
        n_pass++;
      else
        $display("FAIL %s: got st=%0d re=%0b pr=%0b sc=%0d hs=%0d lv=%0d, want st=%0d re=%0b pr=%0b sc=%0d hs=%0d lv=%0d",
                 e.name, state, run_en, position_reset, score, high_score, lives,
                 e.st, e.re, e.pr, e.sc, e.hs, e.lv);
    end
  end

  task automatic step(input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = nm; e.st = e_st; e.re = e_re; e.pr = e_pr;
    e.sc = e_sc; e.hs = e_hs; e.lv = e_lv;
    q.push_back(e);
  endtask

  task automatic set_st(input logic [1:0] s, input logic re, input logic pr);
    e_st = s; e_re = re; e_pr = pr;
  endtask

  // four game ticks in DYING; the fourth resumes or ends the game
  task automatic freeze_out(input bit to_over);
    game_tick = 1'b1;
    repeat (3) step("freeze_wait");
    if (to_over) begin
      set_st(2'd3, 1'b0, 1'b1);
      if (e_sc > e_hs) e_hs = e_sc;
      step("freeze_game_over");
    end else begin
      set_st(2'd1, 1'b1, 1'b1);
      step("freeze_resume");
    end
    game_tick = 1'b0;
  endtask

  task automatic collide(input string nm);
    collided = 1'b1;
    set_st(2'd2, 1'b0, 1'b0);
    e_lv = e_lv - 2'd1;
    step(nm);
    collided = 1'b0;
  endtask

  task automatic start_game;
    start_button = 1'b1; set_st(2'd0, 1'b0, 1'b1); step("go_to_idle");
    start_button = 1'b0; step("idle_wait");
    start_button = 1'b1; set_st(2'd1, 1'b1, 1'b0); e_sc = 8'd0; e_lv = 2'd3;
    step("restart");
    start_button = 1'b0;
  endtask

  initial begin
    // reset with button held: no edge until it drops and rises
    start_button = 1'b1;
    set_st(2'd0, 1'b0, 1'b1); e_sc = 8'd0; e_hs = 8'd0; e_lv = 2'd3;
    step("reset");
    step("reset_hold");
    reset = 1'b0;
    step("btn_held");
    step("btn_held2");
    start_button = 1'b0; step("btn_low");
    start_button = 1'b1; set_st(2'd1, 1'b1, 1'b0); step("start");
    start_button = 1'b0;

    for (int k = 1; k <= 5; k++) begin
      pipe_passed = 1'b1; e_sc = 8'(k); step("pass");
    end
    collided = 1'b1;
    collide("collide_over_pass");
    pipe_passed = 1'b1; step("dying_pass_ignored");
    pipe_passed = 1'b0;
    start_button = 1'b1; step("dying_start_ignored");
    start_button = 1'b0;

    freeze_out(1'b0);
    e_pr = 1'b0; step("pr_one_cycle");
    for (int k = 6; k <= 7; k++) begin
      pipe_passed = 1'b1; e_sc = 8'(k); step("pass2");
    end
    pipe_passed = 1'b0;

    collide("collide2");
    collided = 1'b1;              // held through freeze and into resume
    freeze_out(1'b0);
    collided = 1'b1;
    collide("no_grace");
    freeze_out(1'b1);
    pipe_passed = 1'b1; step("over_hold");
    pipe_passed = 1'b0;

    start_game();
    for (int k = 1; k <= 3; k++) begin
      pipe_passed = 1'b1; e_sc = 8'(k); step("pass3");
    end
    pipe_passed = 1'b0;
    for (int c = 0; c < 3; c++) begin
      collide("collide3");
      freeze_out(e_lv == 2'd0);
    end

    start_game();
    for (int k = 1; k <= 260; k++) begin
      pipe_passed = 1'b1; e_sc = (k > 255) ? 8'd255 : 8'(k); step("saturate");
    end
    pipe_passed = 1'b0;

    collide("collide4");
    game_tick = 1'b1;
    repeat (2) step("mid_freeze");
    game_tick = 1'b0;
    reset = 1'b1;
    set_st(2'd0, 1'b0, 1'b1); e_sc = 8'd0; e_hs = 8'd0; e_lv = 2'd3;
    step("reset_mid_dying");
    reset = 1'b0;
    step("post_reset_idle");

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
